// File: rtl/cpu_seq_pkg.sv
// Shared constants for the cpu_seq control sequencer: state encodings,
// trap-cause codes and the reset value of the instruction register.
package cpu_seq_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_seq_instret_ctr.sv
// 64-bit retired-instruction counter with enable and async active-high reset.
// Only compiled when CPU_SEQ_INSTRET_EN is defined.
`ifdef CPU_SEQ_INSTRET_EN
module instret_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/cpu_seq.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer owning pc and IR.
// Define CPU_SEQ_INSTRET_EN to build the 64-bit retired-instruction counter.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            CLK100MHZ,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  input  logic            dec_illegal,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_rd_en,
  input  logic            taken_branch,
  input  logic [XLEN-1:0] target,
  output logic            dmem_req,
  input  logic            dmem_ready,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic [XLEN-1:0] pc,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] epc,
  output logic [63:0]     instret
);

  // Handshake: a request (imem_req / dmem_req) rises on entry to its state and
  // stays high with a stable address until the matching ready is sampled high
  // on a rising edge; ready in any other state is ignored.

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_epc;
  logic [31:0]     r_instr;
  logic [1:0]      r_cause;

  logic [2:0]      w_next_state;
  logic [1:0]      w_exec_cause;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_retire;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_retire   = (r_state == ST_WB);

  always_comb begin
    w_exec_cause = CAUSE_NONE;
    if (dec_illegal) begin
      w_exec_cause = CAUSE_ILLEGAL;
    end else if (taken_branch && misaligned(target[1:0])) begin
      w_exec_cause = CAUSE_MISALIGN;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:  if (imem_ready) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (w_exec_cause != CAUSE_NONE) begin
          w_next_state = ST_TRAP;
        end else if (dec_is_load || dec_is_store) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM:    if (dmem_ready) w_next_state = ST_WB;
      ST_WB:     w_next_state = ST_FETCH;
      ST_TRAP:   w_next_state = ST_FETCH;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_VECTOR;
      r_next_pc <= RESET_VECTOR;
      r_epc     <= '0;
      r_instr   <= NOP_INSTR;
      r_cause   <= CAUSE_NONE;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_FETCH: if (imem_ready) r_instr <= imem_rdata;
        ST_EXEC: begin
          r_next_pc <= taken_branch ? target : w_pc_plus4;
          r_cause   <= w_exec_cause;
        end
        ST_WB:   r_pc <= r_next_pc;
        ST_TRAP: begin
          r_epc <= r_pc;
          r_pc  <= TRAP_VECTOR;
        end
        default: ;
      endcase
    end
  end

  // Requests are gated by rst so they drop the moment reset is asserted.
  assign imem_req   = (r_state == ST_FETCH) && !rst;
  assign dmem_req   = (r_state == ST_MEM) && !rst;
  assign rf_we      = w_retire && dec_rd_en && !rst;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign state      = r_state;
  assign epc        = r_epc;
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = trap ? r_cause : CAUSE_NONE;

`ifdef CPU_SEQ_INSTRET_EN
  instret_ctr u_instret_ctr (
    .clk     (CLK100MHZ),
    .rst     (rst),
    .i_en    (w_retire),
    .o_count (instret)
  );
`else
  assign instret = 64'd0;
`endif

endmodule
